// File: rtl/run_ctrl_if.sv
// Run-controller handshake bundle: start/halt requests in, reset domains and run status out.
interface run_ctrl_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 32
);
  logic                start;
  logic                halt_req;
  logic [CHANNELS-1:0] rst_n_out;
  logic                running;
  logic                done;
  logic                timeout;
  logic [CNT_W-1:0]    cycle_count;

  modport master (
    output start, halt_req,
    input  rst_n_out, running, done, timeout, cycle_count
  );

  modport slave (
    input  start, halt_req,
    output rst_n_out, running, done, timeout, cycle_count
  );
endinterface

// File: rtl/run_controller.sv
// Sequenced reset release and bounded run control for a set of reset domains.
// Define RUN_CTRL_TIMEOUT_EN to end a run automatically after MAX_CYCLES.
module run_controller #(
  parameter int CHANNELS     = 4,
  parameter int RESET_CYCLES = 2,
  parameter int STAGGER      = 1,
  parameter int MAX_CYCLES   = 100,
  parameter int CNT_W        = 32
) (
  input  logic       clk,
  input  logic       reset,
  run_ctrl_if.slave  io
);

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    RELEASE,
    RUN,
    DONE
  } state_t;

  localparam logic [15:0] HOLD_LAST = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] REL_LAST  = 16'((CHANNELS - 1) * STAGGER);

  if (CHANNELS < 1 || CHANNELS > 16 || RESET_CYCLES < 1 ||
      STAGGER < 0 || MAX_CYCLES < 1) begin : g_bad_cfg
    $error("run_controller: illegal parameter set");
  end

  state_t           state, state_d;
  logic [15:0]      tick_cnt, tick_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state    <= state_d;
      tick_cnt <= tick_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    tick_d  = tick_cnt;
    done_d  = done_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    unique case (state)
      IDLE, DONE: begin
        if (io.start) begin
          state_d = HOLD;
          tick_d  = '0;
          done_d  = 1'b0;
          tmo_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (tick_cnt == HOLD_LAST) begin
          state_d = RELEASE;
          tick_d  = '0;
        end else begin
          tick_d = tick_cnt + 16'd1;
        end
      end
      RELEASE: begin
        if (tick_cnt == REL_LAST) begin
          state_d = RUN;
        end else begin
          tick_d = tick_cnt + 16'd1;
        end
      end
      RUN: begin
        // halt takes priority over the limit in the same cycle
        if (io.halt_req) begin
          state_d = DONE;
          done_d  = 1'b1;
          tmo_d   = 1'b0;
        end
`ifdef RUN_CTRL_TIMEOUT_EN
        else if (cnt_q == CNT_W'(MAX_CYCLES)) begin
          state_d = DONE;
          done_d  = 1'b1;
          tmo_d   = 1'b1;
        end
`endif
        else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Domain i comes out of reset i*STAGGER cycles into RELEASE
  always_comb begin
    io.rst_n_out = '0;
    unique case (state)
      RELEASE: begin
        for (int i = 0; i < CHANNELS; i++) begin
          io.rst_n_out[i] = (tick_cnt >= 16'(i * STAGGER));
        end
      end
      RUN, DONE: io.rst_n_out = '1;
      default:   io.rst_n_out = '0;
    endcase
  end

  assign io.running     = (state == RUN);
  assign io.done        = done_q;
  assign io.timeout     = tmo_q;
  assign io.cycle_count = cnt_q;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: default config on dut_a, fast 4-bit config on dut_b.
// Both the RUN_CTRL_TIMEOUT_EN and default builds are covered.
module tb_run_controller;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  run_ctrl_if #(.CHANNELS(4), .CNT_W(32)) a ();
  run_ctrl_if #(.CHANNELS(4), .CNT_W(4))  b ();

  run_controller dut_a (
    .clk   (clk),
    .reset (reset),
    .io    (a.slave)
  );

  run_controller #(
    .CHANNELS(4), .RESET_CYCLES(2), .STAGGER(0),
    .MAX_CYCLES(10), .CNT_W(4)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .io    (b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic pulse_start_a;
    a.start = 1'b1;
    tick();
    a.start = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (a.rst_n_out !== 4'b0000) begin
      errors++;
      $display("FAIL reset_rst_n: got %b want 0000", a.rst_n_out);
    end
    checks++;
    if ({a.running, a.done, a.timeout} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000",
               {a.running, a.done, a.timeout});
    end
    checks++;
    if (a.cycle_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d want 0", a.cycle_count);
    end
    checks++;
    if (b.rst_n_out !== 4'b0000 || b.cycle_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_b: got %b/%0d want 0000/0",
               b.rst_n_out, b.cycle_count);
    end
  endtask

  task automatic test_release_seq;
    logic [3:0] exp_rst [1:6];
    exp_rst[1] = 4'b0000;
    exp_rst[2] = 4'b0000;
    exp_rst[3] = 4'b0001;
    exp_rst[4] = 4'b0011;
    exp_rst[5] = 4'b0111;
    exp_rst[6] = 4'b1111;
    pulse_start_a();
    for (int c = 1; c <= 6; c++) begin
      checks++;
      if (a.rst_n_out !== exp_rst[c] || a.running !== 1'b0) begin
        errors++;
        $display("FAIL release_c%0d: got %b run=%b want %b run=0",
                 c, a.rst_n_out, a.running, exp_rst[c]);
      end
      tick();
    end
    checks++;
    if (a.running !== 1'b1 || a.cycle_count !== 32'd0) begin
      errors++;
      $display("FAIL run_entry: got run=%b cnt=%0d want run=1 cnt=0",
               a.running, a.cycle_count);
    end
  endtask

  task automatic test_halt;
    repeat (10) tick();
    checks++;
    if (a.cycle_count !== 32'd10) begin
      errors++;
      $display("FAIL run_count: got %0d want 10", a.cycle_count);
    end
    a.halt_req = 1'b1;
    tick();
    a.halt_req = 1'b0;
    checks++;
    if ({a.done, a.timeout, a.running} !== 3'b100) begin
      errors++;
      $display("FAIL halt_flags: got d/t/r=%b want 100",
               {a.done, a.timeout, a.running});
    end
    checks++;
    if (a.cycle_count !== 32'd10 || a.rst_n_out !== 4'b1111) begin
      errors++;
      $display("FAIL halt_hold: got %0d/%b want 10/1111",
               a.cycle_count, a.rst_n_out);
    end
    repeat (5) tick();
    checks++;
    if (a.done !== 1'b1 || a.cycle_count !== 32'd10) begin
      errors++;
      $display("FAIL done_sticky: got d=%b cnt=%0d want 1/10",
               a.done, a.cycle_count);
    end
  endtask

  task automatic test_start_ignored;
    pulse_start_a();
    checks++;
    if (a.done !== 1'b0 || a.cycle_count !== 32'd0 ||
        a.rst_n_out !== 4'b0000) begin
      errors++;
      $display("FAIL restart_clear: got d=%b cnt=%0d rst=%b want 0/0/0000",
               a.done, a.cycle_count, a.rst_n_out);
    end
    repeat (6) tick();
    repeat (3) tick();
    a.start = 1'b1;
    tick();
    a.start = 1'b0;
    checks++;
    if (a.running !== 1'b1 || a.cycle_count !== 32'd4) begin
      errors++;
      $display("FAIL start_in_run: got run=%b cnt=%0d want 1/4",
               a.running, a.cycle_count);
    end
    tick();
    checks++;
    if (a.cycle_count !== 32'd5 || a.rst_n_out !== 4'b1111) begin
      errors++;
      $display("FAIL start_in_run2: got %0d/%b want 5/1111",
               a.cycle_count, a.rst_n_out);
    end
    a.halt_req = 1'b1;
    tick();
    a.halt_req = 1'b0;
  endtask

  task automatic test_reset_mid_release;
    do_reset();
    pulse_start_a();
    repeat (3) tick();
    checks++;
    if (a.rst_n_out !== 4'b0011) begin
      errors++;
      $display("FAIL pre_reset: got %b want 0011", a.rst_n_out);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (a.rst_n_out !== 4'b0000 || a.running !== 1'b0 ||
        a.done !== 1'b0 || a.cycle_count !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: got rst=%b r=%b d=%b cnt=%0d want 0000/0/0/0",
               a.rst_n_out, a.running, a.done, a.cycle_count);
    end
    tick();
    reset = 1'b0;
    a.halt_req = 1'b1;
    repeat (4) tick();
    a.halt_req = 1'b0;
    checks++;
    if (a.rst_n_out !== 4'b0000 || a.running !== 1'b0 || a.done !== 1'b0) begin
      errors++;
      $display("FAIL stay_idle: got rst=%b r=%b d=%b want 0000/0/0",
               a.rst_n_out, a.running, a.done);
    end
  endtask

  task automatic start_b_to_run;
    b.start = 1'b1;
    tick();
    b.start = 1'b0;
    tick();
    tick();
    checks++;
    if (b.rst_n_out !== 4'b1111 || b.running !== 1'b0) begin
      errors++;
      $display("FAIL stagger0: got %b run=%b want 1111 run=0",
               b.rst_n_out, b.running);
    end
    tick();
  endtask

  task automatic test_coincident;
    do_reset();
    start_b_to_run();
    repeat (10) tick();
    checks++;
    if (b.running !== 1'b1 || b.cycle_count !== 4'd10) begin
      errors++;
      $display("FAIL b_run10: got run=%b cnt=%0d want 1/10",
               b.running, b.cycle_count);
    end
    b.halt_req = 1'b1;
    tick();
    b.halt_req = 1'b0;
    checks++;
    if ({b.done, b.timeout} !== 2'b10 || b.cycle_count !== 4'd10) begin
      errors++;
      $display("FAIL coincident: got d/t=%b cnt=%0d want 10/10",
               {b.done, b.timeout}, b.cycle_count);
    end
  endtask

  task automatic test_limit_b;
    do_reset();
    start_b_to_run();
`ifdef RUN_CTRL_TIMEOUT_EN
    for (int i = 0; i < 40 && b.done !== 1'b1; i++) tick();
    checks++;
    if ({b.done, b.timeout, b.running} !== 3'b110 ||
        b.cycle_count !== 4'd10) begin
      errors++;
      $display("FAIL b_timeout: got d/t/r=%b cnt=%0d want 110/10",
               {b.done, b.timeout, b.running}, b.cycle_count);
    end
`else
    repeat (20) tick();
    checks++;
    if (b.cycle_count !== 4'd15 || b.running !== 1'b1) begin
      errors++;
      $display("FAIL saturate: got cnt=%0d run=%b want 15/1",
               b.cycle_count, b.running);
    end
    b.halt_req = 1'b1;
    tick();
    b.halt_req = 1'b0;
`endif
  endtask

  task automatic test_limit_a;
    do_reset();
    pulse_start_a();
    repeat (6) tick();
`ifdef RUN_CTRL_TIMEOUT_EN
    for (int i = 0; i < 300 && a.done !== 1'b1; i++) tick();
    checks++;
    if ({a.done, a.timeout, a.running} !== 3'b110 ||
        a.cycle_count !== 32'd100) begin
      errors++;
      $display("FAIL a_timeout: got d/t/r=%b cnt=%0d want 110/100",
               {a.done, a.timeout, a.running}, a.cycle_count);
    end
    repeat (5) tick();
    checks++;
    if (a.timeout !== 1'b1 || a.cycle_count !== 32'd100) begin
      errors++;
      $display("FAIL timeout_sticky: got t=%b cnt=%0d want 1/100",
               a.timeout, a.cycle_count);
    end
    pulse_start_a();
    checks++;
    if ({a.done, a.timeout} !== 2'b00 || a.cycle_count !== 32'd0) begin
      errors++;
      $display("FAIL timeout_clear: got d/t=%b cnt=%0d want 00/0",
               {a.done, a.timeout}, a.cycle_count);
    end
`else
    repeat (150) tick();
    checks++;
    if (a.running !== 1'b1 || a.timeout !== 1'b0 ||
        a.cycle_count !== 32'd150) begin
      errors++;
      $display("FAIL no_limit: got r=%b t=%b cnt=%0d want 1/0/150",
               a.running, a.timeout, a.cycle_count);
    end
`endif
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    a.start    = 1'b0;
    a.halt_req = 1'b0;
    b.start    = 1'b0;
    b.halt_req = 1'b0;
    #2;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_release_seq();
    test_halt();
    test_start_ignored();
    test_reset_mid_release();
    test_coincident();
    test_limit_b();
    test_limit_a();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
- REQ-001: The block SHALL have one clock and one reset; reset SHALL be asynchronous and active-high.
- REQ-002: Parameter CHANNELS, default 4: number of reset-domain outputs (1..16).
- REQ-003: Parameter RESET_CYCLES, default 2: cycles all channels are held in reset after start (>=1).
- REQ-004: Parameter STAGGER, default 1: cycles between consecutive channel releases (>=0).
- REQ-005: Parameter MAX_CYCLES, default 100: run-cycle limit (>=1, < 2^CNT_W).
- REQ-006: Parameter CNT_W, default 32: cycle counter width.
- REQ-007: clk  input  1  system clock; all state updates on rising edge.
- REQ-008: reset  input  1  asynchronous active-high reset.
- REQ-009: start  input  1  single-cycle request to begin a run sequence.
- REQ-010: halt_req  input  1  run-termination request from the controlled core.
- REQ-011: rst_n_out  output  CHANNELS  active-low reset per domain; bit i drives domain i.
- REQ-012: running  output  1  high while in RUN.
- REQ-013: done  output  1  sticky run-complete flag.
- REQ-014: timeout  output  1  sticky flag: run ended by cycle limit.
- REQ-015: cycle_count  output  CNT_W  cycles spent in RUN.

Function
- REQ-016: FSM states SHALL be IDLE, HOLD, RELEASE, RUN, DONE.
- REQ-017: IDLE: start=1 -> HOLD next cycle; rst_n_out=0, cycle_count cleared to 0, done/timeout cleared.
- REQ-018: HOLD: rst_n_out all 0 for exactly RESET_CYCLES cycles, then RELEASE.
- REQ-019: RELEASE: bit i of rst_n_out SHALL go 1 at cycle i*STAGGER after entering RELEASE (bit 0 on first RELEASE cycle); once all CHANNELS bits are 1 -> RUN next cycle.
- REQ-020: STAGGER=0: all bits release together on the first RELEASE cycle.
- REQ-021: RUN: cycle_count increments by 1 per cycle; running=1; rst_n_out all 1.
- REQ-022: RUN with halt_req=1 -> DONE next cycle, done=1, timeout=0; cycle_count frozen.
- REQ-023: Limit behaviour governed by REQ-030/031.
- REQ-024: halt_req and limit reached in the same cycle: halt wins, timeout stays 0.
- REQ-025: DONE: rst_n_out held all 1; done/timeout/cycle_count held; start=1 -> HOLD, clearing done, timeout, cycle_count.
- REQ-026: start in HOLD, RELEASE or RUN SHALL be ignored; halt_req outside RUN SHALL be ignored.
- REQ-027: cycle_count SHALL saturate at all-ones, never wrap.

Reset
- REQ-028: reset=1, at any time incl. mid-RELEASE or mid-RUN, SHALL immediately force: state IDLE, rst_n_out all 0, running 0, done 0, timeout 0, cycle_count 0.
- REQ-029: After reset deasserts, the block SHALL remain in IDLE until start.

Configuration
- REQ-030: With RUN_CTRL_TIMEOUT_EN defined: in RUN, when cycle_count reaches MAX_CYCLES (and halt_req=0) -> DONE next cycle, done=1, timeout=1, cycle_count=MAX_CYCLES.
- REQ-031: Without RUN_CTRL_TIMEOUT_EN: no cycle limit; RUN exits only on halt_req or reset; timeout tied 0; MAX_CYCLES unused.

Verification
- REQ-032: Defaults, start pulse at cycle 0 -> rst_n_out=0000 cycles 1-2, bits 0,1,2,3 rise at cycles 3,4,5,6, running=1 from cycle 7.
- REQ-033: Timeout enabled, MAX_CYCLES=100, no halt_req -> done=1, timeout=1, cycle_count=100, running=0; sticky until next start.
- REQ-034: halt_req at RUN cycle 10 -> done=1, timeout=0, cycle_count=10; halt_req and limit coincident (MAX_CYCLES=10) -> timeout=0.
- REQ-035: reset pulse mid-RELEASE (bits 0,1 released) -> rst_n_out=0000 same cycle, state IDLE; start pulses during RUN -> no effect.
- REQ-036: CNT_W=4, timeout disabled, 20 RUN cycles -> cycle_count holds 15; STAGGER=0 -> all bits release in one cycle.
